// File: rtl/pe_noc_pkg.sv
// pe_noc_pkg: shared packet field positions, packet width helper and scheduler states
package pe_noc_pkg;
  localparam int DIR_LSB   = 0;
  localparam int XHOP_LSB  = 2;
  localparam int YHOP_BIT  = 4;
  localparam int TS_BIT    = 5;
  localparam int ZERO_LSB  = 6;
  localparam int SPIKE_BIT = 9;
  localparam int NODE_LSB  = 10;
  localparam int RES_LSB   = 12;
  function automatic int pkt_w(input int filter_width);
    return 9 + 3 * filter_width;
  endfunction
  typedef enum logic [1:0] {IDLE, SEND, ADVANCE} sched_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping round
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  // scanning from the far end lets the nearest requester overwrite earlier hits
  always_comb begin
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pe_packet_scheduler.sv
// pe_packet_scheduler: timestep-ordered round-robin injection of source packets into one router port
module pe_packet_scheduler
  import pe_noc_pkg::*;
#(
  parameter int FILTER_WIDTH = 8,
  parameter int NUM_SRC = 4,
  localparam int PKT_W = pkt_w(FILTER_WIDTH),
  localparam int PW = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_SRC-1:0]       in_valid,
  input  logic [NUM_SRC*PKT_W-1:0] in_packet,
  output logic [NUM_SRC-1:0]       in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PKT_W-1:0]         out_packet,
  output logic                     cur_ts,
  output logic                     ts_advance,
  output logic [3:0]               spike_count
);
  sched_state_e state, nxt;
  logic [PKT_W-1:0] pkts [NUM_SRC];
  logic [NUM_SRC-1:0] sent_mask, eligible, grant, done_mask;
  logic [PW-1:0] rr_ptr, held_idx, grant_idx;
  logic [3:0] acc;
  logic pick, finish;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign pkts[i] = in_packet[i*PKT_W +: PKT_W];
    assign eligible[i] = in_valid[i] & ~sent_mask[i] & (pkts[i][TS_BIT] == cur_ts);
  end

  rr_arbiter #(.N(NUM_SRC)) u_arb (.req(eligible), .ptr(rr_ptr), .grant(grant));

  // a grant taken while in reset would be acknowledged and then lost
  assign pick = rst_n && state == IDLE && en && |eligible;
  assign in_ready = pick ? grant : '0;
  assign finish = state == SEND && out_ready;
  assign done_mask = sent_mask | (NUM_SRC'(1) << held_idx);
  assign out_valid = state == SEND;
  assign ts_advance = state == ADVANCE;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) if (grant[i]) grant_idx = PW'(i);
  end

  always_comb
    nxt = state == IDLE ? (pick ? SEND : IDLE)
        : state == SEND ? (out_ready ? (&done_mask ? ADVANCE : IDLE) : SEND)
        : IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_packet  <= '0;
      held_idx    <= '0;
      sent_mask   <= '0;
      rr_ptr      <= '0;
      acc         <= '0;
      cur_ts      <= 1'b0;
      spike_count <= '0;
    end else begin
      state <= nxt;
      if (pick) begin
        out_packet <= pkts[grant_idx];
        held_idx   <= grant_idx;
      end
      if (finish) begin
        sent_mask <= done_mask;
        rr_ptr    <= held_idx == PW'(NUM_SRC - 1) ? '0 : held_idx + 1'b1;
        acc       <= acc == 4'd15 ? acc : acc + 4'(out_packet[SPIKE_BIT]);
      end
      if (ts_advance) begin
        cur_ts      <= ~cur_ts;
        sent_mask   <= '0;
        spike_count <= acc;
        acc         <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pe_packet_scheduler.sv
// tb_pe_packet_scheduler: queue-driven sources checked cycle by cycle against a timestep/round-robin model
module tb_pe_packet_scheduler;
  localparam int N = 4;
  localparam int W = 33;

  logic clk, rst_n, en, out_ready;
  logic [N-1:0] in_valid, in_ready;
  logic [N*W-1:0] in_packet;
  logic out_valid, cur_ts, ts_advance;
  logic [W-1:0] out_packet;
  logic [3:0] spike_count;

  pe_packet_scheduler dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_packet(in_packet),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_packet(out_packet), .cur_ts(cur_ts), .ts_advance(ts_advance),
    .spike_count(spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [W-1:0] srcq [N][$];
  bit sticky = 0;
  int v_pct = 100, en_pct = 100, or_pct = 100;
  int grants [$];
  int adv_cnt = 0;

  bit m_hold = 0, m_adv = 0, m_ts = 0;
  bit [N-1:0] m_sent = '0;
  int m_g = 0, m_rr = 0, m_acc = 0, m_cnt = 0;
  logic [W-1:0] m_pkt = '0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [W-1:0] mk(input bit ts, input bit sp);
    logic [63:0] r;
    r = {$urandom, $urandom};
    mk = r[W-1:0];
    mk[5] = ts;
    mk[9] = sp;
    mk[8:6] = 3'b000;
  endfunction

  function automatic int left();
    left = 0;
    for (int i = 0; i < N; i++) left += srcq[i].size();
  endfunction

  task automatic cyc();
    logic [N-1:0] ei;
    int idx;
    logic [W-1:0] p;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = srcq[i].size() > 0 && $urandom_range(99) < v_pct;
      in_packet[i*W +: W] = in_valid[i] ? srcq[i][0] : mk($urandom_range(1), $urandom_range(1));
    end
    en = $urandom_range(99) < en_pct;
    out_ready = $urandom_range(99) < or_pct;
    #1;
    ei = '0;
    idx = -1;
    if (rst_n && !m_hold && !m_adv && en)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (idx < 0 && in_valid[i] && !m_sent[i] && in_packet[i*W+5] == m_ts) idx = i;
      end
    if (idx >= 0) ei[idx] = 1'b1;
    chk("in_ready", in_ready, ei);
    chk("out_valid", out_valid, m_hold);
    chk("out_packet", out_packet, m_pkt);
    chk("cur_ts", cur_ts, m_ts);
    chk("ts_advance", ts_advance, m_adv);
    chk("spike_count", spike_count, m_cnt);
    if (idx >= 0) grants.push_back(idx);
    if (ts_advance === 1'b1) adv_cnt++;
    @(posedge clk);
    if (!rst_n) begin
      m_hold = 0; m_adv = 0; m_ts = 0; m_sent = '0; m_rr = 0; m_acc = 0; m_cnt = 0; m_pkt = '0;
    end else if (m_adv) begin
      m_ts = !m_ts; m_sent = '0; m_cnt = m_acc; m_acc = 0; m_adv = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_sent[m_g] = 1'b1;
        m_rr = (m_g + 1) % N;
        m_acc = m_acc + m_pkt[9] > 15 ? 15 : m_acc + m_pkt[9];
        m_hold = 0;
        m_adv = m_sent == '1;
      end
    end else if (idx >= 0) begin
      p = in_packet[idx*W +: W];
      m_hold = 1; m_g = idx; m_pkt = p;
    end
    if (idx >= 0 && !sticky) void'(srcq[idx].pop_front());
    #1;
  endtask

  initial begin
    logic [W-1:0] held;
    int c;
    rst_n = 0; en = 0; out_ready = 0; in_valid = '0; in_packet = '0;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) cyc();
    rst_n = 1;
    // four ts=0 packets, spikes 1,1,0,1, held valid after acceptance
    sticky = 1;
    for (int i = 0; i < N; i++) srcq[i].push_back(mk(0, i != 2));
    repeat (14) cyc();
    chk("grant_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) chk("grant_order", grants[k], k);
    chk("spike_after_adv", spike_count, 3);
    chk("ts_after_adv", cur_ts, 1);
    chk("adv_once", adv_cnt, 1);
    sticky = 0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    // six alternating-timestep packets per source, starting at the current ts=1
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 6; k++) srcq[i].push_back(mk((k + 1) % 2, $urandom_range(1)));
    or_pct = 0;
    c = 0;
    while (out_valid !== 1'b1 && c < 20) begin cyc(); c++; end
    chk("stall_reach", out_valid, 1);
    held = out_packet;
    repeat (5) begin
      cyc();
      chk("stall_pkt", out_packet, held);
      chk("stall_vld", out_valid, 1);
    end
    or_pct = 60; en_pct = 80; v_pct = 85;
    c = 0;
    while (!(left() == 0 && !m_hold && !m_adv) && c < 3000) begin cyc(); c++; end
    cyc();
    chk("drain_left", left(), 0);
    chk("drain_idle", out_valid, 0);
    chk("adv_total", adv_cnt, 7);
    // reset while a packet is held
    or_pct = 0; en_pct = 100; v_pct = 100;
    for (int i = 0; i < N; i++) srcq[i].push_back(mk(cur_ts, 1));
    c = 0;
    while (out_valid !== 1'b1 && c < 20) begin cyc(); c++; end
    chk("rst_reach", out_valid, 1);
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("rst_vld", out_valid, 0);
    chk("rst_ts", cur_ts, 0);
    repeat (6) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
